jls_stream_parser: RTL and testbench
====================================

# jls_stream_parser

Byte-stream receiver for the JPEG-LS bitstreams that `jls_encoder` produces: it consumes the encoder-side byte interface (valid/last/error/data), walks the marker segments (SOI, SOF55, SOS, other length-prefixed segments, EOI) and extracts image width and height. It delivers the entropy-coded scan bytes in order and flags each byte that follows a 0xFF, so the following bit-level decoder can drop the stuffed MSB. It sits at the front of the decode path, directly facing a captured or looped-back encoder output.

## Interface
- `WLEVEL`, 12, width field bits; legal widths 1..(1<<WLEVEL)-1
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ivalid`  in  1  input byte valid; one byte per asserted cycle, no backpressure
- `ilast`  in  1  qualifies the last byte of a stream; only meaningful with `ivalid`
- `ierror`  in  1  upstream error flag; only meaningful with `ivalid && ilast`
- `idata`  in  8  input byte
- `onew`  out  1  one-cycle pulse: SOS accepted, `owidth`/`oheight` valid until next `onew`
- `owidth`  out  WLEVEL  image width (SOF55 X field, low WLEVEL bits)
- `oheight`  out  16  image height (SOF55 Y field)
- `ovalid`  out  1  scan byte valid
- `odata`  out  8  scan byte
- `ostuff`  out  1  with `ovalid`: previous scan byte was 0xFF, MSB of `odata` is a stuffed 0
- `olast`  out  1  one-cycle pulse: stream finished (EOI or abort)
- `oerror`  out  1  asserted only together with `olast`: stream was malformed or aborted

## Operation
- States: IDLE, SOI2, MARK1, MARK2, LENH, LENL, SKIP, SOF, SOS, SCAN.
- IDLE: wait for 0xFF -> SOI2; SOI2: 0xD8 -> MARK1, any other byte -> error.
- MARK1 expects 0xFF (else error); MARK2 reads the marker code. 0xFF fill bytes in MARK2 are absorbed. 0xD9 -> finish without error. Any other code -> LENH/LENL, loading a 16-bit length counter with (length-2).
- Length < 2 -> error. Code 0xF7 -> SOF (length must be 11). Code 0xDA -> SOS (length must be 8). Other codes -> SKIP, which discards (length-2) bytes and then returns to MARK1.
- SOF byte index 0..8: P, Yh, Yl, Xh, Xl, Nf, C, HV, Tq. Y latches `oheight`; X latches `owidth` (low WLEVEL bits).
- SOS byte index 0..5: Ns, Cs, Tm, NEAR, ILV, PT. After the last byte: `onew` pulses and the state moves to SCAN. SOS before any SOF -> error.
- SCAN uses a one-byte hold register and a hold-valid flag. For each new byte b:
  - hold==0xFF and b[7]==1: hold is a marker prefix, so discard it. b==0xD9 -> finish OK; any other marker -> error (no restart-marker support).
  - Otherwise: emit hold if hold-valid, with `ostuff` = (byte before hold was 0xFF). Then load b.
- Finish: `olast` pulses and all state returns to IDLE (header outputs retained). A new SOI may follow on the very next byte.
- Error: `olast` and `oerror` pulse together, then return to IDLE. Pending hold byte is dropped.
- `ivalid && ilast` on a byte that does not complete EOI -> error. `ierror` with `ilast` -> error, even if the byte is the EOI code.
- `ilast` on the 0xD9 that completes EOI with `ierror`=0 -> normal finish.

## Timing
- Reset values: all outputs 0. The FSM goes to IDLE and the hold-valid flag clears.
- All outputs are registered. `onew`, `olast`, `oerror` assert the cycle after the triggering input byte.
- Scan byte k appears on `ovalid` the cycle after scan byte k+1 is accepted, so throughput equals input rate. Gaps in `ivalid` stall output with no loss.
- `ovalid` and `olast` never assert in the same cycle. The final pending hold at EOI is always the marker prefix and is not emitted.
- `rst` mid-stream aborts silently: no `olast` is produced.

## Configuration
- `JLS_PARSER_STRICT_EN` defined: additional header checks, each failure -> error at the offending byte:
  - P==8, Nf==1, Ns==1, NEAR==0, ILV==0, PT==0.
  - X in 1..(1<<WLEVEL)-1 and Y != 0.
- Not defined: these fields are ignored and X is truncated to WLEVEL bits. The SOF/SOS length checks and all marker-sequence checks remain active in both builds.

## Test plan
- Encoder stream for 4x2 image (FFD8, FFF7 000B 08 0002 0004 01 01 11 00, FFDA 0008 01 01 00 00 00 00, scan 12 34, FFD9) -> `onew` once with `owidth`=4, `oheight`=2; `odata` 0x12, 0x34; `olast`=1, `oerror`=0.
- Scan bytes FF 5A 77 then FFD9 -> `odata` FF (ostuff=0), 5A (ostuff=1), 77 (ostuff=0), then clean `olast`.
- Unknown segment FFE0 0004 AA BB between SOI and SOF -> skipped; header and scan output identical to test 1.
- `ilast` on second scan byte (no EOI) -> `olast`=`oerror`=1 next cycle. The next stream, fed immediately afterwards, parses cleanly.
- Strict build, SOS with NEAR=1 -> error pulse, no `onew`. Non-strict build -> `onew` and normal scan output.
- `ivalid` toggled every other cycle over test 1 -> same byte sequence and flags; `ovalid` never coincides with `olast`.

Source files
------------

// File: rtl/jls_stream_parser.sv
// JPEG-LS byte-stream parser: walks the marker segments, captures the frame size and forwards scan bytes with stuffing flags.
// Optional build macro JLS_PARSER_STRICT_EN adds header field and frame-size checks.
module jls_stream_parser #(
   parameter int WLEVEL = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ivalid,
   input  logic              ilast,
   input  logic              ierror,
   input  logic [7:0]        idata,
   output logic              onew,
   output logic [WLEVEL-1:0] owidth,
   output logic [15:0]       oheight,
   output logic              ovalid,
   output logic [7:0]        odata,
   output logic              ostuff,
   output logic              olast,
   output logic              oerror
);

   typedef enum logic [3:0] {
      IDLE, SOI2, MARK1, MARK2, LENH, LENL, SKIP, SOF, SOS, SCAN
   } state_t;

   state_t      state;
   logic [7:0]  code;
   logic [7:0]  hi_byte;
   logic [15:0] cnt;
   logic [3:0]  idx;
   logic        have_sof;
   logic [7:0]  hold;
   logic        hold_valid;
   logic        prev_ff;

   logic [15:0] seg_word;
   logic        hold_marker;
   logic        eoi_hit;
   logic        hdr_err;
   logic        fail;
   logic        finish;

   // Header errors are judged against the byte on idata; hi_byte holds the previously seen high byte.
   always_comb begin
      seg_word    = {hi_byte, idata};
      hold_marker = (state == SCAN) && hold_valid && (hold == 8'hFF) && idata[7];
      eoi_hit     = ((state == MARK2) && (idata == 8'hD9)) ||
                    (hold_marker && (idata == 8'hD9));
      hdr_err     = 1'b0;
      case (state)
         SOI2:  hdr_err = (idata != 8'hD8);
         MARK1: hdr_err = (idata != 8'hFF);
         LENL:  hdr_err = (seg_word < 16'd2) ||
                          ((code == 8'hF7) && (seg_word != 16'd11)) ||
                          ((code == 8'hDA) && ((seg_word != 16'd8) || !have_sof));
         SCAN:  hdr_err = hold_marker && (idata != 8'hD9);
`ifdef JLS_PARSER_STRICT_EN
         SOF:   hdr_err = ((idx == 4'd0) && (idata != 8'd8)) ||
                          ((idx == 4'd2) && (seg_word == 16'd0)) ||
                          ((idx == 4'd4) && ((seg_word == 16'd0) ||
                                             ((seg_word >> WLEVEL) != 16'd0))) ||
                          ((idx == 4'd5) && (idata != 8'd1));
         SOS:   hdr_err = ((idx == 4'd0) && (idata != 8'd1)) ||
                          ((idx >= 4'd3) && (idata != 8'd0));
`endif
         default: hdr_err = 1'b0;
      endcase
      fail   = ivalid && (hdr_err || (ilast && (!eoi_hit || ierror)));
      finish = ivalid && eoi_hit && !fail;
   end

   // Single FSM; all outputs are registered and the pulse outputs default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         code       <= 8'd0;
         hi_byte    <= 8'd0;
         cnt        <= 16'd0;
         idx        <= 4'd0;
         have_sof   <= 1'b0;
         hold       <= 8'd0;
         hold_valid <= 1'b0;
         prev_ff    <= 1'b0;
         onew       <= 1'b0;
         owidth     <= '0;
         oheight    <= 16'd0;
         ovalid     <= 1'b0;
         odata      <= 8'd0;
         ostuff     <= 1'b0;
         olast      <= 1'b0;
         oerror     <= 1'b0;
      end else begin
         onew   <= 1'b0;
         ovalid <= 1'b0;
         ostuff <= 1'b0;
         olast  <= 1'b0;
         oerror <= 1'b0;
         if (fail || finish) begin
            olast      <= 1'b1;
            oerror     <= fail;
            state      <= IDLE;
            hold_valid <= 1'b0;
            prev_ff    <= 1'b0;
            have_sof   <= 1'b0;
         end else if (ivalid) begin
            case (state)
               IDLE:  if (idata == 8'hFF) state <= SOI2;
               SOI2:  state <= MARK1;
               MARK1: state <= MARK2;
               MARK2: begin
                  if (idata != 8'hFF) begin
                     code  <= idata;
                     state <= LENH;
                  end
               end
               LENH: begin
                  hi_byte <= idata;
                  state   <= LENL;
               end
               LENL: begin
                  idx <= 4'd0;
                  cnt <= seg_word - 16'd2;
                  if (code == 8'hF7)
                     state <= SOF;
                  else if (code == 8'hDA)
                     state <= SOS;
                  else if (seg_word == 16'd2)
                     state <= MARK1;
                  else
                     state <= SKIP;
               end
               SKIP: begin
                  if (cnt == 16'd1)
                     state <= MARK1;
                  else
                     cnt <= cnt - 16'd1;
               end
               SOF: begin
                  idx <= idx + 4'd1;
                  case (idx)
                     4'd1: hi_byte <= idata;
                     4'd2: oheight <= seg_word;
                     4'd3: hi_byte <= idata;
                     4'd4: owidth  <= seg_word[WLEVEL-1:0];
                     4'd8: begin
                        have_sof <= 1'b1;
                        state    <= MARK1;
                     end
                     default: ;
                  endcase
               end
               SOS: begin
                  idx <= idx + 4'd1;
                  if (idx == 4'd5) begin
                     onew       <= 1'b1;
                     state      <= SCAN;
                     hold_valid <= 1'b0;
                     prev_ff    <= 1'b0;
                  end
               end
               SCAN: begin
                  // A marker prefix never reaches here, so the held byte is always real scan data.
                  if (hold_valid) begin
                     ovalid <= 1'b1;
                     odata  <= hold;
                     ostuff <= prev_ff;
                  end
                  prev_ff    <= hold_valid && (hold == 8'hFF);
                  hold       <= idata;
                  hold_valid <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jls_stream_parser.sv
// Bench for jls_stream_parser: byte vectors with attached expected events, checked through a scoreboard queue.
module tb_jls_stream_parser;

   localparam int WLEVEL = 12;
   localparam logic [1:0] K_NONE = 2'd0, K_BYTE = 2'd1, K_NEW = 2'd2, K_LAST = 2'd3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ivalid = 1'b0;
   logic              ilast = 1'b0;
   logic              ierror = 1'b0;
   logic [7:0]        idata = 8'd0;
   logic              onew;
   logic [WLEVEL-1:0] owidth;
   logic [15:0]       oheight;
   logic              ovalid;
   logic [7:0]        odata;
   logic              ostuff;
   logic              olast;
   logic              oerror;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic        err;
      logic [1:0]  kind;
      logic [7:0]  expData;
      logic        expFlag;
      logic [15:0] expW;
      logic [15:0] expH;
   } vec_t;

   vec_t       vecs[$];
   vec_t       sb[$];
   logic [7:0] scanQ[$];
   logic [15:0] curW = 16'd0;
   logic [15:0] curH = 16'd0;
   int checks = 0;
   int errors = 0;

   jls_stream_parser #(.WLEVEL(WLEVEL)) dut (
      .clk(clk), .rst(rst), .ivalid(ivalid), .ilast(ilast), .ierror(ierror), .idata(idata),
      .onew(onew), .owidth(owidth), .oheight(oheight), .ovalid(ovalid), .odata(odata),
      .ostuff(ostuff), .olast(olast), .oerror(oerror)
   );

   always #5 clk = ~clk;

   task automatic addByte(input logic [7:0] d, input logic l, input logic e,
                          input logic [1:0] k, input logic [7:0] ed, input logic ef);
      vec_t v;
      v.data = d; v.last = l; v.err = e; v.kind = k;
      v.expData = ed; v.expFlag = ef; v.expW = curW; v.expH = curH;
      vecs.push_back(v);
   endtask

   task automatic addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0);
      addByte(8'hD8, 0, 0, K_NONE, 0, 0);
   endtask

   task automatic addSof(input logic [15:0] w, input logic [15:0] h);
      logic [7:0] b[15];
      curW = w; curH = h;
      b = '{8'hFF, 8'hF7, 8'h00, 8'h0B, 8'h08, h[15:8], h[7:0], w[15:8], w[7:0],
            8'h01, 8'h01, 8'h11, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 13; i++) addByte(b[i], 0, 0, K_NONE, 0, 0);
   endtask

   // With nearErr set the stream stops at the NEAR byte, where an error pulse is expected.
   task automatic addSos(input logic [7:0] nearVal, input logic nearErr);
      logic [7:0] b[8];
      b = '{8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h01, 8'h00, nearVal};
      for (int i = 0; i < 7; i++) addByte(b[i], 0, 0, K_NONE, 0, 0);
      if (nearErr) begin
         addByte(b[7], 0, 0, K_LAST, 0, 1);
      end else begin
         addByte(b[7], 0, 0, K_NONE, 0, 0);
         addByte(8'h00, 0, 0, K_NONE, 0, 0);
         addByte(8'h00, 0, 0, K_NEW, 0, 0);
      end
   endtask

   // Scan byte i is expected when byte i+1 arrives, stuffed when byte i-1 was 0xFF.
   task automatic addScanEoi(input logic eoiErr);
      int n;
      n = scanQ.size();
      for (int i = 0; i < n; i++) begin
         if (i == 0)
            addByte(scanQ[0], 0, 0, K_NONE, 0, 0);
         else
            addByte(scanQ[i], 0, 0, K_BYTE, scanQ[i-1], (i > 1) && (scanQ[i-2] == 8'hFF));
      end
      addByte(8'hFF, 0, 0, K_BYTE, scanQ[n-1], (n > 1) && (scanQ[n-2] == 8'hFF));
      addByte(8'hD9, 1, eoiErr, K_LAST, 0, eoiErr);
      scanQ.delete();
   endtask

   task automatic addBasic();
      addSoi();
      addSof(16'd4, 16'd2);
      addSos(8'h00, 0);
      scanQ = '{8'h12, 8'h34};
      addScanEoi(0);
   endtask

   task automatic applyStimulus(input int gap, input string name);
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         ivalid = 1'b1; idata = vecs[i].data; ilast = vecs[i].last; ierror = vecs[i].err;
         if (vecs[i].kind != K_NONE) sb.push_back(vecs[i]);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            ivalid = 1'b0; ilast = 1'b0; ierror = 1'b0;
         end
      end
      @(posedge clk); #1;
      ivalid = 1'b0; ilast = 1'b0; ierror = 1'b0;
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain %s: %0d events still pending, required 0", name, sb.size());
         sb.delete();
      end
      vecs.delete();
   endtask

   task automatic checkOutput(input logic [1:0] k);
      vec_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected: output kind %0d seen, no event expected", k);
         return;
      end
      e = sb.pop_front();
      if (e.kind != k) begin
         errors++;
         $display("[TB] FAIL kind: got %0d, required %0d", k, e.kind);
         return;
      end
      case (k)
         K_BYTE: begin
            checks++;
            if (odata != e.expData || ostuff != e.expFlag) begin
               errors++;
               $display("[TB] FAIL scan byte: got %h/stuff %0b, required %h/stuff %0b",
                        odata, ostuff, e.expData, e.expFlag);
            end
         end
         K_NEW: begin
            checks++;
            if (owidth != e.expW[WLEVEL-1:0] || oheight != e.expH) begin
               errors++;
               $display("[TB] FAIL header: got %0dx%0d, required %0dx%0d",
                        owidth, oheight, e.expW[WLEVEL-1:0], e.expH);
            end
         end
         default: begin
            checks++;
            if (oerror != e.expFlag) begin
               errors++;
               $display("[TB] FAIL last: oerror %0b, required %0b", oerror, e.expFlag);
            end
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ovalid) checkOutput(K_BYTE);
         if (onew) checkOutput(K_NEW);
         if (olast) begin
            checks++;
            if (ovalid) begin
               errors++;
               $display("[TB] FAIL overlap: ovalid=1 with olast, required 0");
            end
            checkOutput(K_LAST);
         end
      end
   end

   task automatic checkResetState(input string name);
      @(negedge clk);
      checks++;
      if ({onew, owidth, oheight, ovalid, odata, ostuff, olast, oerror} != '0) begin
         errors++;
         $display("[TB] FAIL %s: outputs new=%0b w=%0d h=%0d v=%0b d=%h s=%0b l=%0b e=%0b, required all 0",
                  name, onew, owidth, oheight, ovalid, odata, ostuff, olast, oerror);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      checkResetState("reset");
      #1 rst = 1'b0;

      addBasic();
      applyStimulus(0, "basic");

      addSoi(); addSof(16'd300, 16'd7); addSos(8'h00, 0);
      scanQ = '{8'hFF, 8'h5A, 8'h77};
      addScanEoi(0);
      applyStimulus(0, "stuffing");

      // Unknown segment, fill byte and an empty segment ahead of SOF.
      addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hE0, 0, 0, K_NONE, 0, 0);
      addByte(8'h00, 0, 0, K_NONE, 0, 0); addByte(8'h04, 0, 0, K_NONE, 0, 0);
      addByte(8'hAA, 0, 0, K_NONE, 0, 0); addByte(8'hBB, 0, 0, K_NONE, 0, 0);
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hFF, 0, 0, K_NONE, 0, 0);
      addByte(8'hE1, 0, 0, K_NONE, 0, 0); addByte(8'h00, 0, 0, K_NONE, 0, 0);
      addByte(8'h02, 0, 0, K_NONE, 0, 0);
      addSof(16'd4, 16'd2); addSos(8'h00, 0);
      scanQ = '{8'h12, 8'h34};
      addScanEoi(0);
      applyStimulus(0, "skip");

      addSoi(); addSof(16'd4, 16'd2); addSos(8'h00, 0);
      addByte(8'h12, 0, 0, K_NONE, 0, 0);
      addByte(8'h34, 1, 0, K_LAST, 0, 1);
      addBasic();
      applyStimulus(0, "early_last");

      addSoi(); addSof(16'd4, 16'd2);
`ifdef JLS_PARSER_STRICT_EN
      addSos(8'h01, 1);
`else
      addSos(8'h01, 0);
      scanQ = '{8'h12, 8'h34};
      addScanEoi(0);
`endif
      applyStimulus(0, "near");

      addBasic();
      applyStimulus(1, "gapped");

      addSoi(); addSof(16'd9, 16'd3); addSos(8'h00, 0);
      scanQ = '{8'h55, 8'h66};
      addScanEoi(1);
      applyStimulus(0, "ierror_eoi");

      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'h00, 0, 0, K_LAST, 0, 1);
      addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hDA, 0, 0, K_NONE, 0, 0);
      addByte(8'h00, 0, 0, K_NONE, 0, 0); addByte(8'h08, 0, 0, K_LAST, 0, 1);
      addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hD9, 1, 0, K_LAST, 0, 0);
      addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hE0, 0, 0, K_NONE, 0, 0);
      addByte(8'h00, 0, 0, K_NONE, 0, 0); addByte(8'h01, 0, 0, K_LAST, 0, 1);
      addSoi();
      addByte(8'hFF, 0, 0, K_NONE, 0, 0); addByte(8'hF7, 0, 0, K_NONE, 0, 0);
      addByte(8'h00, 0, 0, K_NONE, 0, 0); addByte(8'h0A, 0, 0, K_LAST, 0, 1);
      applyStimulus(0, "marker_errors");

      // Mid-stream reset with a scan byte held: no olast may appear and outputs clear.
      addSoi(); addSof(16'd4, 16'd2); addSos(8'h00, 0);
      addByte(8'h12, 0, 0, K_NONE, 0, 0);
      applyStimulus(0, "pre_reset");
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      checkResetState("mid_reset");
      #1 rst = 1'b0;
      addBasic();
      applyStimulus(0, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
